// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore sequencing controller for the multicycle RISC-V core. One instruction
// is stepped through Fetch / Decode / Execute / Memory / Writeback in 3-5
// cycles. Every enable and mux select of the shared datapath comes from here.
// A memory-ready handshake lets fetch and data accesses stall.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   opcode      instr[6:0] from IR
//   funct3      instr[14:12]
//   funct7_5    instr[30]
//   zero        ALU zero flag; only looked at in BEQ
//   mem_ready   memory completes the current access this cycle
//   PCWrite     PC enable (PCUpdate | Branch & zero)
//   IRWrite     IR / OldPC enable
//   AdrSrc      memory address: 0=PC, 1=ALUOut
//   MemWrite    memory write strobe
//   RegWrite    register file write enable
//   ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     00=PC, 01=OldPC, 10=rs1
//   ALUSrcB     00=rs2, 01=ImmExt, 10=const 4
//   ImmSrc      I=00, S=01, B=10, J=11
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal     one-cycle pulse in DECODE on an unsupported opcode
//   state       current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       pc_update_s;
    logic       branch_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic [1:0] alu_op_s;

    // State register; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused encodings fall to FETCH through the default.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // IR is frozen here, so opcode is lw or sw.
                if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_JAL:     state_d = S_ALUWB;
            S_BEQ:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls (Moore, plus the mem_ready handshake).
    always_comb begin
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        alu_op_s    = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                ir_write_s  = mem_ready;
                pc_update_s = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL: illegal_s = 1'b0;
                    default:                                     illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                alu_op_s = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                alu_op_s = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                // OldPC + 4 goes to ALUOut for the link write in ALUWB.
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pc_update_s = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                alu_op_s = 2'b01;
                branch_s = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    // Write enables and the illegal pulse are suppressed while reset is held.
    always_comb begin
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end else begin
            PCWrite  = pc_update_s | (branch_s & zero);
            IRWrite  = ir_write_s;
            MemWrite = mem_write_s;
            RegWrite = reg_write_s;
            illegal  = illegal_s;
        end
    end

    // ALU operation decode.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op_s)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        // Only R-type (opcode[5]=1) can encode sub.
                        if (opcode[5] & funct7_5) begin
                            ALUControl = 3'b001;
                        end else begin
                            ALUControl = 3'b000;
                        end
                    end
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format from opcode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (opcode)
            OP_LW:   ImmSrc = 2'b00;
            OP_IALU: ImmSrc = 2'b00;
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing controller for the multicycle RISC-V core: a Moore FSM that steps one instruction through Fetch, Decode, Execute, Memory and Writeback over 3–5 cycles. It drives every enable and mux select of the shared datapath: PC, IR, OldPC, the single instruction/data memory port, the register file and the ALU. It sits beside the datapath in the same place the single-cycle control unit occupies. It adds a memory-ready handshake so that fetch and data accesses can stall.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  IR/OldPC enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=const 4
- ImmSrc  out  2  immediate format: I=00, S=01, B=10, J=11
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10
  - 11–15 are unreachable and decode as FETCH on the next edge.
- Internal signals PCUpdate and Branch. PCWrite = PCUpdate | (Branch & zero).
- Unlisted outputs in each state are 0. ALUOp: 00 add, 01 sub, 10 funct-decoded.

States, outputs and transitions:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready. Goes to DECODE if mem_ready, else stays.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state:
  - lw/sw → MEMADR
  - R → EXECR
  - I-ALU → EXECI
  - beq → BEQ
  - jal → JAL
  - any other opcode → FETCH with illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else holds.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held for the whole state. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB, which writes PC+4 to rd.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.

ALU decode (combinational from ALUOp, funct3, opcode[5], funct7_5):
- funct3 000: sub when opcode[5] & funct7_5, else add.
- funct3 010: slt.
- funct3 110: or.
- funct3 111: and.
- Any other funct3: add.

ImmSrc is combinational from opcode in every state; unsupported opcodes give 00.

## Timing
- State register only. All outputs are combinational from state and the inputs listed above; no output registers.
- Reset: state←FETCH at the edge where reset=1. While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0 combinationally.
- First cycle after reset: state=0 with FETCH outputs.
- Cycles per instruction with mem_ready held at 1:
  - lw 5
  - sw 4
  - R, I-ALU 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Wait states: MemWrite stays high through MEMWRITE wait cycles; IRWrite/PCWrite stay low through FETCH wait cycles.
- Reset mid-instruction abandons it: no RegWrite or MemWrite is issued after the reset edge.
- zero is sampled only in BEQ; it is ignored in every other state.

## Test plan
- Reset held 2 cycles then released → state=0. During reset all enables are 0. First FETCH with mem_ready=1 gives IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (0000011), mem_ready=1 → states 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in state 4. ImmSrc=00.
- R-type sub (opcode 0110011, funct3 000, funct7_5=1) → states 0,1,6,8. ALUControl=001 in state 6. Same instruction with funct7_5=0 → ALUControl=000.
- beq with zero=1 → states 0,1,10. PCWrite=1 in state 10, ImmSrc=10. With zero=0 → PCWrite=0 in state 10.
- sw with mem_ready low for 2 cycles in MEMWRITE → state 5 held 3 cycles with MemWrite=1 throughout, then FETCH. jal → states 0,1,9,8 with PCWrite=1 in state 9.
- Opcode 1111111 → illegal=1 for one cycle in DECODE, then FETCH, no writes. Reset asserted in MEMREAD → next state 0 and no MEMWB.
